fetch_ifid_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the

---
 rtl/fetch_ifid_stage.sv | 76 +++++++
 tb/tb_fetch_ifid_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: PC/icache fetch with IF/ID register, 1-entry skid buffer, stall/redirect/halt handling
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ihit,
  input  logic [31:0] imemload_in,
  output logic        iren,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        pc_redirect,
  input  logic [31:0] pc_target,
  input  logic        halt_id,
  output logic [31:0] imemload,
  output logic [31:0] pc_id,
  output logic [31:0] npc_id,
  output logic        valid_id
);
  typedef enum logic {FETCH, HALTED} state_t;
  state_t state, state_nx;
  logic [31:0] pc, buf_instr, buf_pc;
  logic buf_valid, fetching, halt_now, kill;
  assign fetching = state == FETCH;
  assign halt_now = !stall && halt_id && valid_id;
  assign kill = halt_now || (!stall && pc_redirect);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else state <= state_nx;
  always_comb state_nx = (fetching && halt_now) ? HALTED : state;
  always_comb begin
    iren = !rst && fetching && !buf_valid;
    imemaddr = pc;
  end
  // Skid buffer captures a word that arrives while IF/ID is frozen, so it is never refetched
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      imemload <= '0;
      pc_id <= '0;
      npc_id <= '0;
      valid_id <= 1'b0;
      buf_valid <= 1'b0;
      buf_instr <= '0;
      buf_pc <= '0;
    end else if (fetching) begin
      if (stall) begin
        if (ihit && !buf_valid) begin
          buf_instr <= imemload_in;
          buf_pc <= pc;
          buf_valid <= 1'b1;
          pc <= pc + 32'd4;
        end
      end else if (kill) begin
        imemload <= '0;
        valid_id <= 1'b0;
        buf_valid <= 1'b0;
        if (!halt_now) pc <= pc_target;
      end else if (buf_valid) begin
        imemload <= buf_instr;
        pc_id <= buf_pc;
        npc_id <= buf_pc + 32'd4;
        valid_id <= 1'b1;
        buf_valid <= 1'b0;
      end else if (ihit) begin
        imemload <= imemload_in;
        pc_id <= pc;
        npc_id <= pc + 32'd4;
        valid_id <= 1'b1;
        pc <= pc + 32'd4;
      end else begin
        imemload <= '0;
        valid_id <= 1'b0;
      end
    end
endmodule

// File: tb/tb_fetch_ifid_stage.sv
// tb_fetch_ifid_stage: random + directed stimulus, queue-based reference model and scoreboard monitor
module tb_fetch_ifid_stage;
  localparam logic [31:0] RPC = 32'h0000_0200;
  logic clk = 0, rst = 1, ihit = 0, stall = 0, pc_redirect = 0, halt_id = 0;
  logic [31:0] imemload_in = 0, pc_target = 0;
  logic iren, valid_id;
  logic [31:0] imemaddr, imemload, pc_id, npc_id;
  int errors = 0, checks = 0;
  typedef struct {logic [31:0] ins, pc, npc, addr; logic v, ren;} exp_t;
  typedef struct {logic [31:0] instr, pc;} word_t;
  exp_t q[$];
  word_t skid[$];
  logic [31:0] m_pc, m_ins, m_pcid, m_npc;
  logic m_v, m_halt;

  fetch_ifid_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .ihit(ihit), .imemload_in(imemload_in), .iren(iren),
    .imemaddr(imemaddr), .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .halt_id(halt_id), .imemload(imemload), .pc_id(pc_id), .npc_id(npc_id), .valid_id(valid_id)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (imemload !== e.ins || pc_id !== e.pc || npc_id !== e.npc || valid_id !== e.v ||
          imemaddr !== e.addr || iren !== e.ren) begin
        errors++;
        $display("FAIL ifid t=%0t act ins=%h pc=%h npc=%h v=%b addr=%h ren=%b exp ins=%h pc=%h npc=%h v=%b addr=%h ren=%b",
                 $time, imemload, pc_id, npc_id, valid_id, imemaddr, iren,
                 e.ins, e.pc, e.npc, e.v, e.addr, e.ren);
      end
    end
  end

  function automatic void model_reset();
    m_pc = RPC; m_ins = 0; m_pcid = 0; m_npc = 0; m_v = 0; m_halt = 0;
    skid.delete();
  endfunction

  // One fetch cycle: what the stage should show after the coming edge for these inputs
  task automatic cyc(input logic h, input logic [31:0] w, input logic s, input logic r,
                     input logic [31:0] t, input logic hl);
    word_t x;
    @(negedge clk);
    ihit = h; imemload_in = w; stall = s; pc_redirect = r; pc_target = t; halt_id = hl;
    if (!m_halt) begin
      if (s) begin
        if (h && skid.size() == 0) begin
          skid.push_back('{w, m_pc});
          m_pc += 4;
        end
      end else if (hl && m_v) begin
        m_halt = 1; m_ins = 0; m_v = 0; skid.delete();
      end else if (r) begin
        m_pc = t; m_ins = 0; m_v = 0; skid.delete();
      end else if (skid.size() > 0) begin
        x = skid.pop_front();
        m_ins = x.instr; m_pcid = x.pc; m_npc = x.pc + 4; m_v = 1;
      end else if (h) begin
        m_ins = w; m_pcid = m_pc; m_npc = m_pc + 4; m_v = 1; m_pc += 4;
      end else begin
        m_ins = 0; m_v = 0;
      end
    end
    q.push_back('{m_ins, m_pcid, m_npc, m_pc, m_v, !m_halt && skid.size() == 0});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; ihit = 0; stall = 0; pc_redirect = 0; halt_id = 0;
    model_reset();
    #2;
    checks++;
    if (imemload !== 0 || pc_id !== 0 || npc_id !== 0 || valid_id !== 0 || iren !== 0 || imemaddr !== RPC) begin
      errors++;
      $display("FAIL reset act ins=%h pc=%h npc=%h v=%b ren=%b addr=%h exp 0/0/0/0/0/%h",
               imemload, pc_id, npc_id, valid_id, iren, imemaddr, RPC);
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (iren !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_iren act=%b exp=1", iren);
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    cyc(1, 32'h3C01_0001, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h8C22_0004, 1, 0, 0, 0);
    cyc(1, 32'hDEAD_0001, 1, 1, 32'h100, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h0000_1111, 0, 0, 0, 0);
    cyc(1, 32'h0000_2222, 1, 0, 0, 0);
    cyc(1, 32'hBAD0_0001, 0, 1, 32'h40, 0);
    cyc(1, 32'h0000_3333, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(1, 32'h0000_4444, 0, 0, 0, 0);
    cyc(1, 32'h0000_5555, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h80, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h0000_6666, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc($urandom % 2, $urandom, $urandom % 2, $urandom % 2, $urandom, $urandom % 2);
    do_reset();
    cyc(1, 32'h0000_7777, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (m_halt && ($urandom % 8 == 0)) do_reset();
      else cyc($urandom % 4 != 0, $urandom, $urandom % 4 == 0, $urandom % 10 == 0,
               $urandom, $urandom % 40 == 0);
    end
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain act=%0d pending exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
